// File: rtl/pad_ctrl_pkg.sv
// Shared types for the pad configuration sequencer: pad control word layout,
// its reset value, sequencer states and a helper that resolves pull conflicts.
package pad_ctrl_pkg;

  localparam int unsigned PAD_BIT_IE  = 0;
  localparam int unsigned PAD_BIT_OE  = 1;
  localparam int unsigned PAD_BIT_PU  = 2;
  localparam int unsigned PAD_BIT_PD  = 3;
  localparam int unsigned PAD_BIT_CS  = 4;
  localparam int unsigned PAD_BIT_DS0 = 5;
  localparam int unsigned PAD_BIT_DS1 = 6;
  localparam int unsigned PAD_BIT_OUT = 7;

  typedef struct packed {
    logic       out;
    logic [1:0] ds;
    logic       cs;
    logic       pd;
    logic       pu;
    logic       oe;
    logic       ie;
  } pad_cfg_t;

  localparam pad_cfg_t PAD_CFG_RST = '{out: 1'b0, ds: 2'b00, cs: 1'b0, pd: 1'b0,
                                       pu: 1'b1, oe: 1'b0, ie: 1'b1};

  typedef enum logic [2:0] {IDLE, APPLY, TURN, ENABLE, ACK} seq_state_e;

  // Pull-up wins when both pulls are requested, so the pad never fights itself.
  function automatic pad_cfg_t pad_cfg_sanitize(input logic [7:0] raw);
    pad_cfg_t c;
    c = pad_cfg_t'(raw);
    if (c.pu && c.pd) c.pd = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pad_in_sync.sv
// NPAD-wide two-flop synchroniser for pad inputs; only built when
// PADCTRL_SYNC_EN is defined (otherwise the input path is combinational).
`ifdef PADCTRL_SYNC_EN
module pad_in_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`endif

// File: rtl/pad_cfg_sequencer.sv
// Serialised config port for NPAD GPIO pad cells with break-before-make OE turnaround.
// Define PADCTRL_SYNC_EN to route pad inputs through a two-flop synchroniser.
module pad_cfg_sequencer
  import pad_ctrl_pkg::*;
#(
  parameter int NPAD     = 8,
  parameter int TURN_CYC = 4,
  parameter int IDX_W    = (NPAD > 1) ? $clog2(NPAD) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_req_i,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [7:0]       cfg_wdata_i,
  output logic             cfg_ack_o,
  output logic             cfg_err_o,
  output logic [7:0]       cfg_rdata_o,
  output logic             busy_o,
  output logic [NPAD-1:0]  pad_ie_o,
  output logic [NPAD-1:0]  pad_oe_o,
  output logic [NPAD-1:0]  pad_i_o,
  output logic [NPAD-1:0]  pad_pu_o,
  output logic [NPAD-1:0]  pad_pd_o,
  output logic [NPAD-1:0]  pad_cs_o,
  output logic [NPAD-1:0]  pad_ds0_o,
  output logic [NPAD-1:0]  pad_ds1_o,
  input  logic [NPAD-1:0]  pad_c_i,
  output logic [NPAD-1:0]  gpio_in_o
);

  localparam int               CNT_W    = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN_CYC - 1);
  localparam logic [IDX_W:0]   NPAD_LIM = (IDX_W + 1)'(NPAD);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             oe_up_q, oe_chg_q, err_q;
  logic [7:0]       rdata_q;
  pad_cfg_t         pad_q [NPAD];

  logic     accept, idx_ok, conflict, oe_up, oe_chg, enable_oe;
  pad_cfg_t cur_cfg, new_cfg, apply_cfg;

  always_comb begin
    cur_cfg = PAD_CFG_RST;
    for (int p = 0; p < NPAD; p++) begin
      if (cfg_idx_i == IDX_W'(p)) cur_cfg = pad_q[p];
    end
  end

  assign accept   = (state_q == IDLE) && cfg_req_i;
  assign idx_ok   = {1'b0, cfg_idx_i} < NPAD_LIM;
  assign conflict = cfg_wdata_i[PAD_BIT_PU] & cfg_wdata_i[PAD_BIT_PD];
  assign new_cfg  = pad_cfg_sanitize(cfg_wdata_i);
  assign oe_chg   = cur_cfg.oe ^ new_cfg.oe;
  assign oe_up    = ~cur_cfg.oe & new_cfg.oe;

  // A rising OE is held off here and only raised after the turnaround.
  always_comb begin
    apply_cfg    = new_cfg;
    apply_cfg.oe = new_cfg.oe & cur_cfg.oe;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    enable_oe = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_req_i) state_d = (cfg_we_i && idx_ok) ? APPLY : ACK;
      end
      APPLY: begin
        cnt_d   = CNT_LOAD;
        state_d = oe_chg_q ? TURN : ACK;
      end
      TURN: begin
        if (cnt_q == '0) begin
          if (oe_up_q) begin
            state_d   = ENABLE;
            enable_oe = 1'b1;
          end else begin
            state_d = ACK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ENABLE:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      oe_up_q  <= 1'b0;
      oe_chg_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q    <= cfg_idx_i;
        oe_up_q  <= cfg_we_i & oe_up;
        oe_chg_q <= cfg_we_i & oe_chg;
        err_q    <= ~idx_ok | (cfg_we_i & conflict);
        if (!idx_ok)        rdata_q <= '0;
        else if (!cfg_we_i) rdata_q <= cur_cfg;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the pad array is reset on purpose: pads must come out of reset in a safe, undriven state.
    if (!rst_ni) begin
      for (int p = 0; p < NPAD; p++) pad_q[p] <= PAD_CFG_RST;
    end else begin
      for (int p = 0; p < NPAD; p++) begin
        if (accept && cfg_we_i && idx_ok && (cfg_idx_i == IDX_W'(p))) begin
          pad_q[p] <= apply_cfg;
        end else if (enable_oe && (idx_q == IDX_W'(p))) begin
          pad_q[p].oe <= 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < NPAD; p++) begin : g_pad
    assign pad_ie_o[p]  = pad_q[p][PAD_BIT_IE];
    assign pad_oe_o[p]  = pad_q[p][PAD_BIT_OE];
    assign pad_pu_o[p]  = pad_q[p][PAD_BIT_PU];
    assign pad_pd_o[p]  = pad_q[p][PAD_BIT_PD];
    assign pad_cs_o[p]  = pad_q[p][PAD_BIT_CS];
    assign pad_ds0_o[p] = pad_q[p][PAD_BIT_DS0];
    assign pad_ds1_o[p] = pad_q[p][PAD_BIT_DS1];
    assign pad_i_o[p]   = pad_q[p][PAD_BIT_OUT];
  end

  assign cfg_ack_o   = (state_q == ACK);
  assign cfg_err_o   = cfg_ack_o & err_q;
  assign cfg_rdata_o = rdata_q;
  assign busy_o      = (state_q != IDLE);

`ifdef PADCTRL_SYNC_EN
  pad_in_sync #(.W(NPAD)) u_in_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pad_c_i & pad_ie_o),
    .q_o    (gpio_in_o)
  );
`else
  assign gpio_in_o = pad_c_i & pad_ie_o;
`endif

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Self-checking bench for pad_cfg_sequencer: directed vector table, random
// transactions against a word-level pad model, and a mid-sequence reset.
module tb_pad_cfg_sequencer;

  localparam int NPAD     = 6;
  localparam int TURN_CYC = 4;
  localparam int IDX_W    = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             cfg_req_i, cfg_we_i;
  logic [IDX_W-1:0] cfg_idx_i;
  logic [7:0]       cfg_wdata_i;
  logic             cfg_ack_o, cfg_err_o, busy_o;
  logic [7:0]       cfg_rdata_o;
  logic [NPAD-1:0]  pad_ie_o, pad_oe_o, pad_i_o, pad_pu_o, pad_pd_o, pad_cs_o;
  logic [NPAD-1:0]  pad_ds0_o, pad_ds1_o, pad_c_i, gpio_in_o;

  pad_cfg_sequencer #(.NPAD(NPAD), .TURN_CYC(TURN_CYC), .IDX_W(IDX_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_ack_o(cfg_ack_o), .cfg_err_o(cfg_err_o),
    .cfg_rdata_o(cfg_rdata_o), .busy_o(busy_o),
    .pad_ie_o(pad_ie_o), .pad_oe_o(pad_oe_o), .pad_i_o(pad_i_o),
    .pad_pu_o(pad_pu_o), .pad_pd_o(pad_pd_o), .pad_cs_o(pad_cs_o),
    .pad_ds0_o(pad_ds0_o), .pad_ds1_o(pad_ds1_o),
    .pad_c_i(pad_c_i), .gpio_in_o(gpio_in_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic             we;
    logic [IDX_W-1:0] idx;
    logic [7:0]       wdata;
    int               lat;
    logic             err;
    logic [7:0]       rdata;
    logic             chk_rd;
  } vec_t;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] mcfg [NPAD];
  logic [8*NPAD-1:0] dut_vec;

  always_comb begin
    dut_vec = '0;
    for (int p = 0; p < NPAD; p++)
      dut_vec[p*8 +: 8] = {pad_i_o[p], pad_ds1_o[p], pad_ds0_o[p], pad_cs_o[p],
                           pad_pd_o[p], pad_pu_o[p], pad_oe_o[p], pad_ie_o[p]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8*NPAD-1:0] model_vec();
    logic [8*NPAD-1:0] v;
    for (int p = 0; p < NPAD; p++) v[p*8 +: 8] = mcfg[p];
    return v;
  endfunction

  function automatic logic [NPAD-1:0] model_ie();
    logic [NPAD-1:0] v;
    for (int p = 0; p < NPAD; p++) v[p] = mcfg[p][0];
    return v;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < NPAD; p++) mcfg[p] = 8'h05;
  endfunction

  // Expected ack latency / err / rdata from the pad rules, before the model is updated.
  function automatic void model_exp(input logic we, input logic [IDX_W-1:0] idx,
                                    input logic [7:0] wd, output int lat,
                                    output logic err, output logic [7:0] rd,
                                    output logic chk_rd);
    logic ok, old_oe, new_oe;
    ok     = int'(idx) < NPAD;
    old_oe = ok ? mcfg[idx][1] : 1'b0;
    new_oe = wd[1];
    chk_rd = !we || !ok;
    rd     = 8'h00;
    if (!ok) begin
      lat = 1; err = 1'b1;
    end else if (!we) begin
      lat = 1; err = 1'b0; rd = mcfg[idx];
    end else begin
      lat = 2 + ((old_oe != new_oe) ? TURN_CYC : 0) + ((!old_oe && new_oe) ? 1 : 0);
      err = wd[2] & wd[3];
    end
  endfunction

  // Runs one request, checking every pad each cycle; updates the model at ack.
  task automatic xact(input logic we, input logic [IDX_W-1:0] idx, input logic [7:0] wd,
                      output int lat, output logic err, output logic [7:0] rd);
    logic ok, up;
    logic [7:0] nw, ew;
    logic [8*NPAD-1:0] ev;
    ok = int'(idx) < NPAD;
    nw = wd;
    if (wd[2] && wd[3]) nw[3] = 1'b0;
    up = we && ok && !mcfg[ok ? idx : '0][1] && nw[1];
    lat = 0; err = 1'b0; rd = 8'h00;
    cfg_req_i = 1'b1; cfg_we_i = we; cfg_idx_i = idx; cfg_wdata_i = wd;
    @(posedge clk_i);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      ev = model_vec();
      if (we && ok) begin
        ew    = nw;
        ew[1] = nw[1] && (!up || k >= TURN_CYC + 2);
        ev[int'(idx)*8 +: 8] = ew;
      end
      check("pads_in_seq", 64'(dut_vec), 64'(ev));
      check("busy_in_seq", 64'(busy_o), 64'(1));
      if (cfg_ack_o) begin
        lat = k; err = cfg_err_o; rd = cfg_rdata_o;
        break;
      end
    end
    cfg_req_i = 1'b0;
    if (we && ok) mcfg[idx] = nw;
    @(negedge clk_i);
    check("ack_single", 64'(cfg_ack_o), 64'(0));
    check("busy_after", 64'(busy_o), 64'(0));
  endtask

  initial begin
    vec_t       tbl [16];
    int         lat, elat;
    logic       err, eerr, chk;
    logic [7:0] rd, erd, wd;
    logic       we;
    logic [IDX_W-1:0] idx;

    tbl[0]  = '{1'b0, 3'd3, 8'h00, 1,            1'b0, 8'h05, 1'b1};
    tbl[1]  = '{1'b1, 3'd2, 8'h83, TURN_CYC + 3, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 3'd2, 8'h00, 1,            1'b0, 8'h83, 1'b1};
    tbl[3]  = '{1'b1, 3'd2, 8'h01, TURN_CYC + 2, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 3'd2, 8'h00, 1,            1'b0, 8'h01, 1'b1};
    tbl[5]  = '{1'b1, 3'd0, 8'h0D, 2,            1'b1, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 8'h00, 1,            1'b0, 8'h05, 1'b1};
    tbl[7]  = '{1'b1, 3'd6, 8'hFF, 1,            1'b1, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 3'd7, 8'h00, 1,            1'b1, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 3'd5, 8'hA4, 2,            1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 3'd5, 8'h00, 1,            1'b0, 8'hA4, 1'b1};
    tbl[11] = '{1'b1, 3'd4, 8'h02, TURN_CYC + 3, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b1, 3'd4, 8'h03, 2,            1'b0, 8'h00, 1'b0};
    tbl[13] = '{1'b0, 3'd4, 8'h00, 1,            1'b0, 8'h03, 1'b1};
    tbl[14] = '{1'b1, 3'd4, 8'h8C, TURN_CYC + 2, 1'b1, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 3'd4, 8'h00, 1,            1'b0, 8'h84, 1'b1};

    rst_ni = 1'b0; cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0;
    cfg_wdata_i = '0; pad_c_i = '0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check("rst_pads",  64'(dut_vec), 64'(model_vec()));
    check("rst_ack",   64'(cfg_ack_o), 64'(0));
    check("rst_err",   64'(cfg_err_o), 64'(0));
    check("rst_busy",  64'(busy_o), 64'(0));
    check("rst_rdata", 64'(cfg_rdata_o), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rel_pads", 64'(dut_vec), 64'(model_vec()));

    for (int i = 0; i < 16; i++) begin
      xact(tbl[i].we, tbl[i].idx, tbl[i].wdata, lat, err, rd);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].err));
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(tbl[i].rdata));
    end

    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      idx = IDX_W'($urandom_range(0, 7));
      wd  = 8'($urandom);
      model_exp(we, idx, wd, elat, eerr, erd, chk);
      xact(we, idx, wd, lat, err, rd);
      check("rnd_lat", 64'(lat), 64'(elat));
      check("rnd_err", 64'(err), 64'(eerr));
      if (chk) check("rnd_rdata", 64'(rd), 64'(erd));
      pad_c_i = NPAD'($urandom);
`ifdef PADCTRL_SYNC_EN
      repeat (3) @(negedge clk_i);
`else
      #1;
`endif
      check("gpio_in", 64'(gpio_in_o), 64'(pad_c_i & model_ie()));
    end

    // Reset during the turnaround of an OE 0->1 write.
    @(negedge clk_i);
    xact(1'b1, 3'd1, 8'h05, lat, err, rd);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_idx_i = 3'd1; cfg_wdata_i = 8'h83;
    @(posedge clk_i);
    repeat (3) @(negedge clk_i);
    check("mid_busy",   64'(busy_o), 64'(1));
    check("mid_oe_low", 64'(pad_oe_o[1]), 64'(0));
    check("mid_i_set",  64'(pad_i_o[1]), 64'(1));
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check("mid_rst_pads",  64'(dut_vec), 64'(model_vec()));
    check("mid_rst_busy",  64'(busy_o), 64'(0));
    check("mid_rst_ack",   64'(cfg_ack_o), 64'(0));
    check("mid_rst_rdata", 64'(cfg_rdata_o), 64'(0));
    cfg_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (TURN_CYC + 4) @(negedge clk_i);
    check("mid_no_late_oe", 64'(dut_vec), 64'(model_vec()));
    xact(1'b0, 3'd1, 8'h00, lat, err, rd);
    check("post_rst_read_lat", 64'(lat), 64'(1));
    check("post_rst_read_rd",  64'(rd), 64'(8'h05));
    xact(1'b1, 3'd1, 8'h83, lat, err, rd);
    check("post_rst_write_lat", 64'(lat), 64'(TURN_CYC + 3));
    check("post_rst_write_err", 64'(err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
